// File: rtl/constraint_sweep_ctrl.sv
// Gauss-Seidel sweep sequencer for a rope of points: streams (up, cur, down)
// windows from a sync position RAM through a shared enforce unit and writes results back.
module constraint_sweep_ctrl #(
  parameter int WIDTH      = 32,
  parameter int NUM_POINTS = 16,
  parameter int ITERATIONS = 4,
  localparam int AW = (NUM_POINTS > 2) ? $clog2(NUM_POINTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_x,
  input  logic [WIDTH-1:0] rd_y,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_x,
  output logic [WIDTH-1:0] wr_y,
  output logic [WIDTH-1:0] cu_up_x,
  output logic [WIDTH-1:0] cu_up_y,
  output logic [WIDTH-1:0] cu_x,
  output logic [WIDTH-1:0] cu_y,
  output logic [WIDTH-1:0] cu_down_x,
  output logic [WIDTH-1:0] cu_down_y,
  output logic             cu_is_last,
  input  logic [WIDTH-1:0] cu_x_enf,
  input  logic [WIDTH-1:0] cu_y_enf
);

  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_POINTS - 1);
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME0 = 3'd1;
  localparam logic [2:0] S_PRIME1 = 3'd2;
  localparam logic [2:0] S_PRIME2 = 3'd3;
  localparam logic [2:0] S_FETCH  = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [WIDTH-1:0] up_x_q, up_x_d, up_y_q, up_y_d;
  logic [WIDTH-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [WIDTH-1:0] dn_x_q, dn_x_d, dn_y_q, dn_y_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d, last_q, last_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic             is_last;

  assign is_last = (idx_q == LAST_IDX);

  // Sequencing and window register updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    up_x_d  = up_x_q;
    up_y_d  = up_y_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    dn_x_d  = dn_x_q;
    dn_y_d  = dn_y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME0;
          iter_d  = '0;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIME0: state_d = S_PRIME1;
      S_PRIME1: begin
        up_x_d  = rd_x;
        up_y_d  = rd_y;
        idx_d   = AW'(1);
        state_d = S_PRIME2;
      end
      S_PRIME2: begin
        cur_x_d = rd_x;
        cur_y_d = rd_y;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_EVAL;
      S_EVAL: begin
        // The last point has no neighbour below; it sees itself as down.
        if (is_last) begin
          dn_x_d = cur_x_q;
          dn_y_d = cur_y_q;
        end else begin
          dn_x_d = rd_x;
          dn_y_d = rd_y;
        end
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        up_x_d  = cu_x_enf;
        up_y_d  = cu_y_enf;
        cur_x_d = dn_x_q;
        cur_y_d = dn_y_q;
        if (!is_last) begin
          idx_d   = idx_q + AW'(1);
          state_d = S_FETCH;
        end else if (iter_q != LAST_ITER) begin
          iter_d  = iter_q + IW'(1);
          idx_d   = '0;
          state_d = S_PRIME0;
        end else begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output strobes decoded from the next state so they are registered
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    wr_en_d   = (state_d == S_COMMIT);
    wr_addr_d = (state_d == S_COMMIT) ? idx_d : '0;
    last_d    = (idx_d == LAST_IDX);
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    case (state_d)
      S_PRIME0: rd_en_d = 1'b1;
      S_PRIME1: begin
        rd_en_d   = 1'b1;
        rd_addr_d = AW'(1);
      end
      S_FETCH: begin
        if (idx_d != LAST_IDX) begin
          rd_en_d   = 1'b1;
          rd_addr_d = idx_d + AW'(1);
        end else begin
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
        end
      end
      default: begin
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      iter_q    <= '0;
      up_x_q    <= '0;
      up_y_q    <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      dn_x_q    <= '0;
      dn_y_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      last_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      iter_q    <= iter_d;
      up_x_q    <= up_x_d;
      up_y_q    <= up_y_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      dn_x_q    <= dn_x_d;
      dn_y_q    <= dn_y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      last_q    <= last_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign cu_is_last = last_q;
  assign wr_x       = cu_x_enf;
  assign wr_y       = cu_y_enf;
  assign cu_up_x    = up_x_q;
  assign cu_up_y    = up_y_q;
  assign cu_x       = cur_x_q;
  assign cu_y       = cur_y_q;
  assign cu_down_x  = dn_x_q;
  assign cu_down_y  = dn_y_q;

endmodule
